tempsense_sar_ctrl: RTL and testbench



---
 rtl/tempsense_sar_ctrl_if.sv | 48 ++++
 rtl/tempsense_sar_ctrl.sv | 168 ++++++++++++++++
 tb/tb_tempsense_sar_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/tempsense_sar_ctrl_if.sv
// Purpose  : bundles the tempsense_sar_ctrl control, sensor and result signals.
// Latency  : none, wiring only.
// Backpress: none; results are strobed, not handshaken.
//
// Ports (controller view, modport master):
//   i_start, i_continuous : conversion request and auto-restart enable
//   i_temp_delay          : delay-cell output from the tempsense core
//   o_dac_data/o_dac_en/o_precharge_n : drive to the tempsense core
//   o_result/o_valid/o_busy           : result, one-cycle strobe, activity flag
// The slave modport is the sequencer/sensor side. N_VDAC must match the
// controller's N_VDAC.
interface tempsense_sar_ctrl_if #(
    parameter int N_VDAC = 6
);
    logic              i_start;
    logic              i_continuous;
    logic              i_temp_delay;
    logic [N_VDAC-1:0] o_dac_data;
    logic              o_dac_en;
    logic              o_precharge_n;
    logic [N_VDAC-1:0] o_result;
    logic              o_valid;
    logic              o_busy;

    modport master (
        input  i_start,
        input  i_continuous,
        input  i_temp_delay,
        output o_dac_data,
        output o_dac_en,
        output o_precharge_n,
        output o_result,
        output o_valid,
        output o_busy
    );

    modport slave (
        output i_start,
        output i_continuous,
        output i_temp_delay,
        input  o_dac_data,
        input  o_dac_en,
        input  o_precharge_n,
        input  o_result,
        input  o_valid,
        input  o_busy
    );
endinterface

// File: rtl/tempsense_sar_ctrl.sv
// Purpose  : successive-approximation controller for the tempsense delay cell.
// Latency  : 4*N_VDAC cycles per conversion; result strobed the cycle after the last evaluate.
// Backpress: none; i_start is only honoured in IDLE, results cannot be stalled.
//
// Ports:
//   clk    : sensor clock, all state changes on its rising edge
//   reset  : asynchronous, active-high
//   io_sar : tempsense_sar_ctrl_if.master (start/continuous/delay in,
//            DAC drive, result, valid strobe and busy out)
// Optional feature: define TEMPSENSE_AVG_EN to average 2^N_AVG conversions
// per result; without it every conversion produces a result and no
// accumulator or conversion counter exists.
module tempsense_sar_ctrl #(
    parameter int N_VDAC = 6,
    parameter int N_AVG  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    tempsense_sar_ctrl_if.master io_sar
);

    localparam int BW = $clog2(N_VDAC);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHARGE,
        S_TRANSITION,
        S_MEASURE,
        S_EVALUATE
    } state_t;

    state_t            r_state;
    logic [BW-1:0]     r_bit;
    logic [N_VDAC-1:0] r_sar;
    logic [N_VDAC-1:0] r_dac_data;
    logic              r_dac_en;
    logic              r_precharge_n;
    logic [N_VDAC-1:0] r_result;
    logic              r_valid;
    logic              r_busy;

    logic [N_VDAC-1:0] w_trial;
    logic [N_VDAC-1:0] w_sar_next;
    logic              w_conv_end;
    logic              w_last_conv;
    logic [N_VDAC-1:0] w_result_next;

    // Trial code for the bit under test; sar has that bit still cleared.
    assign w_trial    = r_sar | (N_VDAC'(1) << r_bit);
    // A slow delay cell (1) means the trial code overshot: keep the bit clear.
    assign w_sar_next = io_sar.i_temp_delay ? r_sar : w_trial;
    assign w_conv_end = (r_state == S_EVALUATE) && (r_bit == '0);

`ifdef TEMPSENSE_AVG_EN
    localparam int CW = (N_AVG > 0) ? N_AVG : 1;
    localparam int AW = N_VDAC + N_AVG;

    logic [CW-1:0] r_conv;
    logic [AW-1:0] r_acc;
    logic [AW-1:0] w_acc_sum;

    // AW bits hold 2^N_AVG full-scale codes exactly, so the sum cannot wrap.
    assign w_acc_sum     = r_acc + AW'(w_sar_next);
    assign w_last_conv   = (r_conv == CW'((1 << N_AVG) - 1));
    assign w_result_next = N_VDAC'(w_acc_sum >> N_AVG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_conv <= '0;
            r_acc  <= '0;
        end else if (w_conv_end) begin
            if (w_last_conv) begin
                r_conv <= '0;
                r_acc  <= '0;
            end else begin
                r_conv <= r_conv + 1'b1;
                r_acc  <= w_acc_sum;
            end
        end
    end
`else
    assign w_last_conv   = 1'b1;
    assign w_result_next = w_sar_next;
`endif

    // Outputs are registered alongside the state so every control line
    // comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_bit         <= '0;
            r_sar         <= '0;
            r_dac_data    <= '1;
            r_dac_en      <= 1'b0;
            r_precharge_n <= 1'b0;
            r_result      <= '0;
            r_valid       <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (io_sar.i_start) begin
                        r_state       <= S_PRECHARGE;
                        r_bit         <= BW'(N_VDAC - 1);
                        r_sar         <= '0;
                        r_dac_en      <= 1'b1;
                        r_dac_data    <= '1;
                        r_precharge_n <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end
                S_PRECHARGE: begin
                    r_state       <= S_TRANSITION;
                    r_dac_data    <= '0;
                    r_precharge_n <= 1'b1;
                end
                S_TRANSITION: begin
                    r_state    <= S_MEASURE;
                    r_dac_data <= w_trial;
                end
                S_MEASURE: begin
                    r_state <= S_EVALUATE;
                end
                S_EVALUATE: begin
                    if (r_bit != '0) begin
                        r_sar         <= w_sar_next;
                        r_bit         <= r_bit - 1'b1;
                        r_state       <= S_PRECHARGE;
                        r_dac_data    <= '1;
                        r_precharge_n <= 1'b0;
                    end else begin
                        r_sar <= '0;
                        r_bit <= BW'(N_VDAC - 1);
                        if (w_last_conv) begin
                            r_result <= w_result_next;
                            r_valid  <= 1'b1;
                        end
                        // Intermediate averaging conversions always chain on;
                        // a result boundary restarts only in continuous mode.
                        if (!w_last_conv || io_sar.i_continuous) begin
                            r_state       <= S_PRECHARGE;
                            r_dac_data    <= '1;
                            r_precharge_n <= 1'b0;
                        end else begin
                            r_state       <= S_IDLE;
                            r_dac_en      <= 1'b0;
                            r_dac_data    <= '1;
                            r_precharge_n <= 1'b0;
                            r_busy        <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_sar.o_dac_data    = r_dac_data;
    assign io_sar.o_dac_en      = r_dac_en;
    assign io_sar.o_precharge_n = r_precharge_n;
    assign io_sar.o_result      = r_result;
    assign io_sar.o_valid       = r_valid;
    assign io_sar.o_busy        = r_busy;

endmodule

// File: tb/tb_tempsense_sar_ctrl.sv
// Purpose  : self-checking bench for tempsense_sar_ctrl against a threshold sensor model.
// Latency  : expects results 4*N*conversions+1 cycles after the start edge.
// Backpress: none; drives i_start/i_continuous, observes the strobed result.
module tb_tempsense_sar_ctrl;

    localparam int N     = 6;
    localparam int N_AVG = 2;
    localparam int MAXC  = (1 << N) - 1;
`ifdef TEMPSENSE_AVG_EN
    localparam int NCONV = 1 << N_AVG;
`else
    localparam int NCONV = 1;
`endif
    localparam int L = 4 * N * NCONV;   // cycles from start edge to last evaluate

    logic clk;
    logic reset;
    int   threshold;
    int   n_tests;
    int   n_fail;
    int   meas[$];

    tempsense_sar_ctrl_if #(.N_VDAC(N)) sar_if ();

    tempsense_sar_ctrl #(.N_VDAC(N), .N_AVG(N_AVG)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_sar (sar_if)
    );

    // Sensor model: the delay cell is slow whenever the DAC code exceeds the threshold.
    assign sar_if.i_temp_delay = (int'(sar_if.o_dac_data) > threshold);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Ideal SAR outcome: the largest representable code not above the threshold.
    function automatic int sar_model(input int th);
        if (th < 0) return 0;
        if (th > MAXC) return MAXC;
        return th;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_result"}, sar_if.o_result, 0);
        check({tag, "_valid"}, sar_if.o_valid, 0);
        check({tag, "_busy"}, sar_if.o_busy, 0);
        check({tag, "_dac_en"}, sar_if.o_dac_en, 0);
        check({tag, "_dac_data"}, sar_if.o_dac_data, MAXC);
        check({tag, "_pre_n"}, sar_if.o_precharge_n, 0);
    endtask

    // One single-shot request; every conversion cycle is checked against the
    // four-phase pattern, then the strobe cycle and the hold cycle.
    task automatic run_single(input int th, input int exp, input string tag);
        int errs;
        int ph;
        errs = 0;
        threshold = th;
        meas.delete();
        sar_if.i_continuous = 1'b0;
        @(negedge clk) sar_if.i_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= L + 2; k++) begin
            @(negedge clk);
            if (k == 1) sar_if.i_start = 1'b0;
            if (k <= L) begin
                ph = (k - 1) % 4;
                if (sar_if.o_busy !== 1'b1 || sar_if.o_valid !== 1'b0 || sar_if.o_dac_en !== 1'b1) errs++;
                case (ph)
                    0: if (sar_if.o_dac_data !== MAXC[N-1:0] || sar_if.o_precharge_n !== 1'b0) errs++;
                    1: if (sar_if.o_dac_data !== '0 || sar_if.o_precharge_n !== 1'b1) errs++;
                    2: begin
                        if (sar_if.o_precharge_n !== 1'b1) errs++;
                        meas.push_back(int'(sar_if.o_dac_data));
                    end
                    default: begin
                        if (sar_if.o_precharge_n !== 1'b1) errs++;
                        if (int'(sar_if.o_dac_data) != meas[meas.size()-1]) errs++;
                    end
                endcase
            end else if (k == L + 1) begin
                check({tag, "_phase_errs"}, errs, 0);
                check({tag, "_valid"}, sar_if.o_valid, 1);
                check({tag, "_result"}, sar_if.o_result, exp);
                check({tag, "_busy_fall"}, sar_if.o_busy, 0);
                check({tag, "_idle_dac_en"}, sar_if.o_dac_en, 0);
            end else begin
                check({tag, "_valid_drop"}, sar_if.o_valid, 0);
                check({tag, "_result_hold"}, sar_if.o_result, exp);
            end
        end
    endtask

    typedef struct {
        int th;
        int exp;
    } vec_t;

    vec_t vecs[8];
    int   exp_meas[6];
    int   strobe_cyc[$];
    int   strobe_val[$];
    int   ths[4];
    int   acc;
    int   th_r;
    int   errs;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        vecs[0] = '{37, 37};
        vecs[1] = '{-1, 0};
        vecs[2] = '{63, 63};
        vecs[3] = '{100, 63};
        vecs[4] = '{0, 0};
        vecs[5] = '{1, 1};
        vecs[6] = '{31, 31};
        vecs[7] = '{32, 32};
        exp_meas = '{32, 48, 40, 36, 38, 37};

        threshold           = 0;
        sar_if.i_start      = 1'b0;
        sar_if.i_continuous = 1'b0;
        reset               = 1'b0;
        #2 reset = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);

        // Table-driven single-shot conversions, including boundary codes.
        for (int i = 0; i < 8; i++) begin
            run_single(vecs[i].th, vecs[i].exp, $sformatf("vec%0d", i));
            if (i == 0) begin
                for (int j = 0; j < N; j++)
                    check($sformatf("basic_meas%0d", j), meas[j], exp_meas[j]);
            end
        end

        // Randomised thresholds against the ideal-SAR model.
        for (int i = 0; i < 12; i++) begin
            th_r = int'($urandom_range(0, MAXC + 8)) - 4;
            run_single(th_r, sar_model(th_r), $sformatf("rand%0d", i));
        end

        // Continuous mode, then drop i_continuous partway through the 4th result.
        threshold = 10;
        strobe_cyc.delete();
        strobe_val.delete();
        sar_if.i_continuous = 1'b1;
        @(negedge clk) sar_if.i_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 4 * L + 60; k++) begin
            @(negedge clk);
            if (k == 1) sar_if.i_start = 1'b0;
            if (sar_if.o_valid === 1'b1) begin
                strobe_cyc.push_back(k);
                strobe_val.push_back(int'(sar_if.o_result));
            end
            if (k == 4 * L + 1) begin
                check("cont_end_busy", sar_if.o_busy, 0);
                check("cont_end_dac_en", sar_if.o_dac_en, 0);
            end
            if (k == 3 * L + 10) sar_if.i_continuous = 1'b0;
        end
        check("cont_strobe_count", strobe_cyc.size(), 4);
        for (int j = 0; j < 4 && j < strobe_cyc.size(); j++) begin
            check($sformatf("cont_cycle%0d", j), strobe_cyc[j], (j + 1) * L + 1);
            check($sformatf("cont_value%0d", j), strobe_val[j], 10);
        end
        check("cont_final_busy", sar_if.o_busy, 0);

        // Reset in the middle of a conversion.
        threshold = 45;
        @(negedge clk) sar_if.i_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) sar_if.i_start = 1'b0;
        end
        reset = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
        errs = 0;
        for (int k = 0; k < L + 10; k++) begin
            @(negedge clk);
            if (sar_if.o_valid !== 1'b0 || sar_if.o_busy !== 1'b0) errs++;
        end
        check("midreset_quiet", errs, 0);
        run_single(25, 25, "post_reset");

        // i_start pulses while busy, including on the final evaluate edge.
        threshold = 50;
        strobe_cyc.delete();
        @(negedge clk) sar_if.i_start = 1'b1;
        @(posedge clk);
        errs = 0;
        for (int k = 1; k <= 3 * L; k++) begin
            @(negedge clk);
            if (k == 1 || k == 6 || k == L) sar_if.i_start = 1'b0;
            if (k == 5 || k == L - 1) sar_if.i_start = 1'b1;
            if (sar_if.o_valid === 1'b1) strobe_cyc.push_back(k);
            if (k > L && sar_if.o_busy !== 1'b0) errs++;
            if (k == L + 1) check("ign_result", sar_if.o_result, sar_model(50));
        end
        check("ign_strobe_count", strobe_cyc.size(), 1);
        if (strobe_cyc.size() > 0) check("ign_strobe_cycle", strobe_cyc[0], L + 1);
        check("ign_no_restart", errs, 0);

`ifdef TEMPSENSE_AVG_EN
        // Averaging across four conversions with a drifting threshold.
        ths = '{20, 21, 21, 22};
        acc = 0;
        for (int j = 0; j < 4; j++) acc += sar_model(ths[j]);
        strobe_cyc.delete();
        strobe_val.delete();
        threshold = ths[0];
        @(negedge clk) sar_if.i_start = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= L + 2; k++) begin
            @(negedge clk);
            if (k == 1) sar_if.i_start = 1'b0;
            if ((k - 1) % (4 * N) == 0 && (k - 1) / (4 * N) < 4) threshold = ths[(k - 1) / (4 * N)];
            if (sar_if.o_valid === 1'b1) begin
                strobe_cyc.push_back(k);
                strobe_val.push_back(int'(sar_if.o_result));
            end
            if ((k == 4 * N + 1 || k == 8 * N + 1 || k == 12 * N + 1))
                check($sformatf("avg_busy_c%0d", k), sar_if.o_busy, 1);
        end
        check("avg_strobe_count", strobe_cyc.size(), 1);
        if (strobe_cyc.size() > 0) begin
            check("avg_strobe_cycle", strobe_cyc[0], 16 * N + 1);
            check("avg_result", strobe_val[0], acc >> N_AVG);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
